mf_tap_sequencer: RTL and testbench

Control sequencer for the 128-tap heartbeat match filter datapath. It accepts one strobe per new low-pass-filtered sample and starts one filter job per accepted strobe. For each job it issues the filter's load pulse, circular-buffer write offset and tap index sweep. It waits out the datapath's multiply/accumulate pipeline, then flags when the filter output is valid for the peak detector. The block sits between the low-pass filter output and the match filter, and owns the filter's `ready`, `index` and `offset` inputs.

---
 rtl/mf_tap_sequencer.sv | 134 +++++++++++++
 tb/tb_mf_tap_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mf_tap_sequencer.sv
// mf_tap_sequencer: control sequencer for the heartbeat match filter.
// Accepts one sample strobe per job and drives the filter's load pulse,
// circular-buffer write offset and tap index sweep, waits out the MAC
// pipeline, then flags y_valid for the peak detector.
// Optional build macro: MF_SEQ_OVERRUN_CNT_EN enables the saturating
// 8-bit dropped-strobe counter on overrun_count (tied to zero otherwise).
module mf_tap_sequencer #(
  parameter int unsigned TAPS       = 128,
  parameter int unsigned IDX_W      = 7,
  parameter int unsigned PIPE_DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             sample_strobe,
  output logic             mf_ready,
  output logic [IDX_W-1:0] mf_index,
  output logic [IDX_W-1:0] mf_offset,
  output logic             busy,
  output logic             y_valid,
  output logic             overrun,
  output logic [7:0]       overrun_count
);

  localparam int unsigned DRAIN_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(TAPS - 1);
  localparam logic [IDX_W-1:0]   IDX_PENULT = IDX_W'(TAPS - 2);
  localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(PIPE_DEPTH - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               accept;
  logic               drop;

  // Strobe classification: accepted when a new job may start, dropped mid-job.
  always_comb begin
    accept = 1'b0;
    drop   = 1'b0;
    if (sample_strobe) begin
      accept = enable && ((state == IDLE) || (state == DONE));
      drop   = (state == LOAD) || (state == RUN) || (state == DRAIN);
    end
  end

  // Job FSM with registered outputs; the final index TAPS-1 is issued during
  // LOAD and DRAIN so the RUN sweep only needs to cover 0..TAPS-2.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      mf_ready  <= 1'b0;
      mf_index  <= IDX_LAST;
      mf_offset <= '0;
      busy      <= 1'b0;
      y_valid   <= 1'b0;
      overrun   <= 1'b0;
      drain_cnt <= '0;
    end else begin
      mf_ready <= 1'b0;
      y_valid  <= 1'b0;
      overrun  <= drop;
      case (state)
        IDLE: begin
          mf_index <= IDX_LAST;
          if (accept) begin
            state    <= LOAD;
            mf_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          state    <= RUN;
          mf_index <= '0;
        end
        RUN: begin
          if (mf_index == IDX_PENULT) begin
            state     <= DRAIN;
            mf_index  <= IDX_LAST;
            drain_cnt <= DRAIN_INIT;
          end else begin
            mf_index <= mf_index + IDX_ONE;
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state   <= DONE;
            y_valid <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_ONE;
          end
        end
        DONE: begin
          mf_offset <= mf_offset + IDX_ONE;
          if (accept) begin
            state    <= LOAD;
            mf_ready <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          mf_index <= IDX_LAST;
        end
      endcase
    end
  end

`ifdef MF_SEQ_OVERRUN_CNT_EN
  // Saturating count of dropped strobes; cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      overrun_count <= '0;
    end else if (drop && (overrun_count != '1)) begin
      overrun_count <= overrun_count + 8'd1;
    end
  end
`else
  assign overrun_count = '0;
`endif

endmodule

// File: tb/tb_mf_tap_sequencer.sv
// Directed bench for mf_tap_sequencer: a table of single-step/hold vectors
// plus hand-written sequences for back-to-back jobs, overrun saturation and
// reset mid-job.
module tb_mf_tap_sequencer;

`ifdef MF_SEQ_OVERRUN_CNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic       clock;
  logic       reset;
  logic       enable;
  logic       sample_strobe;
  logic       mf_ready;
  logic [6:0] mf_index;
  logic [6:0] mf_offset;
  logic       busy;
  logic       y_valid;
  logic       overrun;
  logic [7:0] overrun_count;

  mf_tap_sequencer #(.TAPS(128), .IDX_W(7), .PIPE_DEPTH(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .sample_strobe (sample_strobe),
    .mf_ready      (mf_ready),
    .mf_index      (mf_index),
    .mf_offset     (mf_offset),
    .busy          (busy),
    .y_valid       (y_valid),
    .overrun       (overrun),
    .overrun_count (overrun_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;
  int yv_seen = 0;
  int ovr_seen = 0;

  // Pulse tallies sampled at each edge (values from the preceding cycle).
  always @(posedge clock) begin
    if (y_valid === 1'b1) yv_seen = yv_seen + 1;
    if (overrun === 1'b1) ovr_seen = ovr_seen + 1;
  end

  typedef struct {
    string nm;
    bit    rst;
    bit    en;
    bit    stb;
    int    hold;
    int    e_ready;
    int    e_index;
    int    e_offset;
    int    e_busy;
    int    e_yv;
    int    e_ovr;
    int    e_ocnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input bit rst, input bit en, input bit stb,
                     input int hold, input int rdy, input int idx, input int off,
                     input int bsy, input int yv, input int ovr, input int ocnt);
    vec_t v;
    v.nm = nm; v.rst = rst; v.en = en; v.stb = stb; v.hold = hold;
    v.e_ready = rdy; v.e_index = idx; v.e_offset = off; v.e_busy = bsy;
    v.e_yv = yv; v.e_ovr = ovr; v.e_ocnt = ocnt;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_vec = n_vec + 1;
    if (got != exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_outputs(input string nm, input int rdy, input int idx,
                             input int off, input int bsy, input int yv,
                             input int ovr, input int ocnt);
    chk({nm, ".mf_ready"},      int'(mf_ready),      rdy);
    chk({nm, ".mf_index"},      int'(mf_index),      idx);
    chk({nm, ".mf_offset"},     int'(mf_offset),     off);
    chk({nm, ".busy"},          int'(busy),          bsy);
    chk({nm, ".y_valid"},       int'(y_valid),       yv);
    chk({nm, ".overrun"},       int'(overrun),       ovr);
    chk({nm, ".overrun_count"}, int'(overrun_count), ocnt);
  endtask

  initial begin
    int c;
    int yv0;
    int ov0;
    c = CNT_EN;

    //  name            rst en stb hold  rdy idx off bsy yv ovr ocnt
    add("reset",         1, 1, 0,   0,   0, 127, 0, 0, 0, 0, 0);
    add("strobe_load",   0, 1, 1,   0,   1, 127, 0, 1, 0, 0, 0);
    add("run_first",     0, 1, 0,   0,   0,   0, 0, 1, 0, 0, 0);
    add("run_idx50",     0, 1, 0,  49,   0,  50, 0, 1, 0, 0, 0);
    add("ovr_strobe",    0, 1, 1,   0,   0,  51, 0, 1, 0, 1, c);
    add("ovr_clear",     0, 1, 0,   0,   0,  52, 0, 1, 0, 0, c);
    add("run_last",      0, 1, 0,  73,   0, 126, 0, 1, 0, 0, c);
    add("drain1",        0, 1, 0,   0,   0, 127, 0, 1, 0, 0, c);
    add("drain2",        0, 1, 0,   0,   0, 127, 0, 1, 0, 0, c);
    add("done",          0, 1, 0,   0,   0, 127, 0, 1, 1, 0, c);
    add("idle_after",    0, 1, 0,   0,   0, 127, 1, 0, 0, 0, c);
    add("en0_strobe",    0, 0, 1,   0,   0, 127, 1, 0, 0, 0, c);
    add("en0_hold",      0, 0, 0,   2,   0, 127, 1, 0, 0, 0, c);
    add("job2_load",     0, 1, 1,   0,   1, 127, 1, 1, 0, 0, c);
    add("en_drop_run",   0, 0, 0,  10,   0,  10, 1, 1, 0, 0, c);
    add("en_drop_done",  0, 0, 0, 118,   0, 127, 1, 1, 1, 0, c);
    add("en_drop_idle",  0, 0, 0,   0,   0, 127, 2, 0, 0, 0, c);
    add("job3_load",     0, 1, 1,   0,   1, 127, 2, 1, 0, 0, c);
    add("job3_idx60",    0, 1, 0,  60,   0,  60, 2, 1, 0, 0, c);
    add("reset_mid",     1, 1, 0,   0,   0, 127, 0, 0, 0, 0, 0);

    reset = 1'b1;
    enable = 1'b0;
    sample_strobe = 1'b0;
    tick();
    tick();

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      enable = vecs[i].en;
      sample_strobe = vecs[i].stb;
      tick();
      reset = 1'b0;
      sample_strobe = 1'b0;
      for (int h = 0; h < vecs[i].hold; h++) tick();
      chk_outputs(vecs[i].nm, vecs[i].e_ready, vecs[i].e_index, vecs[i].e_offset,
                  vecs[i].e_busy, vecs[i].e_yv, vecs[i].e_ovr, vecs[i].e_ocnt);
    end
    chk("table.y_valid_pulses", yv_seen, 2);
    chk("table.overrun_pulses", ovr_seen, 1);

    // Reset mid-job must not leave a pending y_valid behind.
    yv0 = yv_seen;
    enable = 1'b1;
    for (int k = 0; k < 140; k++) tick();
    chk("post_reset.no_y_valid", yv_seen - yv0, 0);
    chk("post_reset.busy", int'(busy), 0);

    // 130 back-to-back jobs: each next strobe lands in the DONE cycle.
    yv0 = yv_seen;
    ov0 = ovr_seen;
    for (int j = 0; j < 130; j++) begin
      sample_strobe = 1'b1;
      tick();
      sample_strobe = 1'b0;
      chk($sformatf("b2b%0d.load", j), int'(mf_ready), 1);
      chk($sformatf("b2b%0d.load_offset", j), int'(mf_offset), j % 128);
      for (int k = 0; k < 130; k++) tick();
      chk($sformatf("b2b%0d.y_valid", j), int'(y_valid), 1);
      chk($sformatf("b2b%0d.done_offset", j), int'(mf_offset), j % 128);
    end
    tick();
    chk("b2b.final_idle_busy", int'(busy), 0);
    chk("b2b.final_offset", int'(mf_offset), 2);
    chk("b2b.y_valid_pulses", yv_seen - yv0, 130);
    chk("b2b.overruns", ovr_seen - ov0, 0);

    // Strobe held high for 400 edges from IDLE: 396 drops, 4 accepts.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ov0 = ovr_seen;
    sample_strobe = 1'b1;
    for (int k = 0; k < 400; k++) tick();
    sample_strobe = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("sat.overrun_pulses", ovr_seen - ov0, 396);
    chk("sat.overrun_count", int'(overrun_count), CNT_EN ? 255 : 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("sat.count_after_reset", int'(overrun_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
